// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main-memory word port between the I-cache refill path and
// the D-cache refill / write-back path. One cache line moves at a time, as
// LINE_WORDS word beats over a valid/ready memory handshake. A one-cycle ready
// pulse back to the requester completes the line.
//
// Sequence: IDLE -> GRANT_I | GRANT_D -> DONE -> IDLE.
// With mem_ready tied high the sequence is:
//   - grant on edge 0
//   - beats on edges 1..LINE_WORDS
//   - ready pulse in cycle LINE_WORDS+1
// That is LINE_WORDS+2 cycles per line, counted IDLE to IDLE.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   i_r_valid, i_addr     I-cache line read request and address
//   i_r_ready, i_rline    one-cycle completion pulse and the line read
//   d_r_valid, d_w_valid  D-cache line read / write-back request
//                         (write wins when both are high)
//   d_addr, d_wline       D-cache address and the line to write
//   d_r_ready, d_w_ready  one-cycle completion pulses
//   d_rline               line read for the D-cache
//   mem_valid, mem_we     beat request to memory; 1 = write beat
//   mem_addr, mem_wdata   beat byte address and write data
//   mem_rdata, mem_ready  read data and beat accept
//   busy                  high whenever a transfer is granted or completing
//
// Line word k sits at bits [32k+31:32k] of every line bus.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_r_valid,
  input  logic [31:0]             i_addr,
  output logic                    i_r_ready,
  output logic [32*LINE_WORDS-1:0] i_rline,

  input  logic                    d_r_valid,
  input  logic                    d_w_valid,
  input  logic [31:0]             d_addr,
  input  logic [32*LINE_WORDS-1:0] d_wline,
  output logic                    d_r_ready,
  output logic                    d_w_ready,
  output logic [32*LINE_WORDS-1:0] d_rline,

  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready,

  output logic                    busy
);

  localparam int CW = $clog2(LINE_WORDS);
  // Byte offset mask inside one line; clearing it gives the line base.
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;          // current beat within the line
  logic            last_grant_d; // 1 = D side won the most recent grant
  logic            op_we;        // latched operation of the granted transfer
  logic [31:0]     base;         // latched line base byte address
  logic [31:0]     wbuf   [LINE_WORDS];
  logic [31:0]     i_line [LINE_WORDS];
  logic [31:0]     d_line [LINE_WORDS];

  // Grant decision and beat bookkeeping
  logic            d_pend;
  logic            grant_d;
  logic            grant_i;
  logic            beat_ok;
  logic            last_beat;
  logic [CW-1:0]   cnt_nxt;
  logic [31:0]     i_base;
  logic [31:0]     d_base;

  assign i_base    = i_addr & ~LINE_MASK;
  assign d_base    = d_addr & ~LINE_MASK;
  assign beat_ok   = mem_valid & mem_ready;
  assign last_beat = (cnt == CW'(LINE_WORDS - 1));
  assign cnt_nxt   = cnt + CW'(1);

  // On a tie, the side that did not win last time is served.
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    d_pend  = d_r_valid | d_w_valid;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_pend && i_r_valid) begin
      grant_d = ~last_grant_d;
      grant_i = last_grant_d;
    end else begin
      grant_d = d_pend;
      grant_i = i_r_valid;
    end
  end

  // Line buses are driven straight from the buffers. They change only while
  // a read fills them, so they stay stable from DONE until the next grant.
  always_comb begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      i_rline[32*k +: 32] = i_line[k];
      d_rline[32*k +: 32] = d_line[k];
    end
  end

  // NOTE: all state below updates with non-blocking assignments, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant_d <= 1'b0;
      op_we        <= 1'b0;
      base         <= '0;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_r_ready    <= 1'b0;
      d_r_ready    <= 1'b0;
      d_w_ready    <= 1'b0;
      busy         <= 1'b0;
      // NOTE: the line buffers are storage that would normally be left
      // unreset. They are cleared here because the line outputs must read
      // zero after reset.
      for (int k = 0; k < LINE_WORDS; k++) begin
        wbuf[k]   <= '0;
        i_line[k] <= '0;
        d_line[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_d) begin
            state        <= GRANT_D;
            last_grant_d <= 1'b1;
            op_we        <= d_w_valid;
            base         <= d_base;
            mem_valid    <= 1'b1;
            mem_we       <= d_w_valid;
            mem_addr     <= d_base;
            mem_wdata    <= d_w_valid ? d_wline[31:0] : 32'd0;
            busy         <= 1'b1;
            // The requester may change d_wline once the grant is taken.
            for (int k = 0; k < LINE_WORDS; k++) begin
              wbuf[k] <= d_wline[32*k +: 32];
            end
          end else if (grant_i) begin
            state        <= GRANT_I;
            last_grant_d <= 1'b0;
            op_we        <= 1'b0;
            base         <= i_base;
            mem_valid    <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= i_base;
            mem_wdata    <= '0;
            busy         <= 1'b1;
          end
        end

        GRANT_I, GRANT_D: begin
          // Beat outputs hold until memory accepts the beat.
          if (beat_ok) begin
            if (!op_we) begin
              if (state == GRANT_I) i_line[cnt] <= mem_rdata;
              else                  d_line[cnt] <= mem_rdata;
            end
            cnt <= cnt_nxt;
            if (last_beat) begin
              state     <= DONE;
              mem_valid <= 1'b0;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              i_r_ready <= (state == GRANT_I);
              d_r_ready <= (state == GRANT_D) & ~op_we;
              d_w_ready <= (state == GRANT_D) &  op_we;
            end else begin
              mem_addr  <= base + 32'({cnt_nxt, 2'b00});
              mem_wdata <= op_we ? wbuf[cnt_nxt] : 32'd0;
            end
          end
        end

        DONE: begin
          // Single completion cycle; new requests are first sampled in IDLE.
          state     <= IDLE;
          i_r_ready <= 1'b0;
          d_r_ready <= 1'b0;
          d_w_ready <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives requester rounds: I only, D only, or both at once. A memory model
// answers every beat with a data word derived from its address, optionally
// stalling with mem_ready low.
//
// For each round a transaction-level reference predicts:
//   - the grant order (tie goes to the side that did not win last)
//   - the operation of each transfer (write wins)
//   - the beat addresses, write data and read lines
// A per-cycle monitor checks the port-level rules:
//   - busy only while a transfer is active
//   - at most one ready pulse at a time
//   - beat outputs held while stalled
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LW_N = 4;
  localparam int LB   = 32 * LW_N;
  localparam logic [31:0] STALL_ADDR = 32'h0000_2004;

  logic          clk;
  logic          rst;
  logic          i_r_valid;
  logic [31:0]   i_addr;
  logic          i_r_ready;
  logic [LB-1:0] i_rline;
  logic          d_r_valid;
  logic          d_w_valid;
  logic [31:0]   d_addr;
  logic [LB-1:0] d_wline;
  logic          d_r_ready;
  logic          d_w_ready;
  logic [LB-1:0] d_rline;
  logic          mem_valid;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          busy;

  mem_port_arbiter #(.LINE_WORDS(LW_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_r_valid (i_r_valid),
    .i_addr    (i_addr),
    .i_r_ready (i_r_ready),
    .i_rline   (i_rline),
    .d_r_valid (d_r_valid),
    .d_w_valid (d_w_valid),
    .d_addr    (d_addr),
    .d_wline   (d_wline),
    .d_r_ready (d_r_ready),
    .d_w_ready (d_w_ready),
    .d_rline   (d_rline),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          stall_mode = 0;   // 0 ready always, 1 random, 2 directed stall at STALL_ADDR
  bit          mon_en = 1'b0;
  bit          model_last_d = 1'b0;
  beat_t       beats[$];
  int          pulses[$];        // 0 = i_r_ready, 1 = d_r_ready, 2 = d_w_ready
  logic [LB-1:0] pulse_lines[$];

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LW_N * 4 - 1);
  endfunction

  // Memory responder and per-cycle monitor
  initial begin
    int          stall_cnt;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic        prev_we;
    stall_cnt  = 0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_wdata = '0;
    prev_we    = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rdata = mem_fn(mem_addr);
      if (stall_mode != 2) stall_cnt = 0;
      case (stall_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (mem_valid && mem_addr == STALL_ADDR && stall_cnt < 3) begin
            mem_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_ready = 1'b1;
          end
        end
      endcase
      if (mon_en && !rst) begin
        check("busy_vs_activity", LB'(busy),
              LB'(mem_valid | i_r_ready | d_r_ready | d_w_ready));
        check("single_pulse", LB'(int'(i_r_ready) + int'(d_r_ready) + int'(d_w_ready) > 1), '0);
        if (prev_stall) begin
          check("stall_hold_valid", LB'(mem_valid), 1);
          check("stall_hold_addr",  LB'(mem_addr),  LB'(prev_addr));
          check("stall_hold_we",    LB'(mem_we),    LB'(prev_we));
          check("stall_hold_wdata", LB'(mem_wdata), LB'(prev_wdata));
        end
        if (mem_valid && mem_ready) beats.push_back('{mem_addr, mem_we, mem_wdata});
        if (i_r_ready) begin pulses.push_back(0); pulse_lines.push_back(i_rline); end
        if (d_r_ready) begin pulses.push_back(1); pulse_lines.push_back(d_rline); end
        if (d_w_ready) begin pulses.push_back(2); pulse_lines.push_back('0); end
        prev_stall = mem_valid && !mem_ready;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_we    = mem_we;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // One requester round: assert the chosen requests, hold each until its ready
  // pulse, then compare everything observed against the transaction model.
  task automatic do_round(input bit req_i, input bit req_d, input bit dw, input bit dr,
                          input logic [31:0] ia, input logic [31:0] da, input logic [LB-1:0] wl,
                          output int first_pulse, output int busy_cycles);
    int  exp_side[$];   // 0 = I, 1 = D
    int  b0, p0, n;
    bit  pend_i, pend_d;
    first_pulse = -1;
    busy_cycles = 0;
    if (req_i && req_d) begin
      if (model_last_d) exp_side = '{0, 1};
      else              exp_side = '{1, 0};
    end else if (req_i) begin
      exp_side = '{0};
    end else begin
      exp_side = '{1};
    end
    model_last_d = (exp_side[exp_side.size()-1] == 1);

    b0 = beats.size();
    p0 = pulses.size();
    i_addr    = ia;
    i_r_valid = req_i;
    d_addr    = da;
    d_wline   = wl;
    d_w_valid = req_d & dw;
    d_r_valid = req_d & dr;
    pend_i = req_i;
    pend_d = req_d;
    n = 0;
    while ((pend_i || pend_d) && n < 400) begin
      @(negedge clk);
      n++;
      if (busy) busy_cycles++;
      // The write line is latched at grant; scribble on it afterwards.
      if (mem_valid && mem_we && d_wline == wl) d_wline = ~wl;
      if (pend_i && i_r_ready) begin
        pend_i = 1'b0;
        i_r_valid = 1'b0;
        if (first_pulse < 0) first_pulse = n;
      end
      if (pend_d && (d_r_ready || d_w_ready)) begin
        pend_d = 1'b0;
        d_r_valid = 1'b0;
        d_w_valid = 1'b0;
        if (first_pulse < 0) first_pulse = n;
      end
    end
    check("round_timeout", LB'({pend_i, pend_d}), '0);
    i_r_valid = 1'b0;
    d_r_valid = 1'b0;
    d_w_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_round", LB'(busy), '0);

    check("pulse_count", LB'(pulses.size() - p0), LB'(exp_side.size()));
    check("beat_count",  LB'(beats.size() - b0),  LB'(exp_side.size() * LW_N));
    for (int t = 0; t < exp_side.size(); t++) begin
      logic [31:0]   bs;
      bit            is_w;
      logic [LB-1:0] exp_line;
      bs   = line_base(exp_side[t] == 1 ? da : ia);
      is_w = (exp_side[t] == 1) && dw;
      for (int j = 0; j < LW_N; j++) exp_line[32*j +: 32] = mem_fn(bs + 32'(4 * j));
      if (p0 + t < pulses.size()) begin
        check("pulse_kind", LB'(pulses[p0 + t]), LB'(exp_side[t] == 0 ? 0 : (is_w ? 2 : 1)));
        if (!is_w) check("read_line", pulse_lines[p0 + t], exp_line);
      end
      for (int j = 0; j < LW_N; j++) begin
        int bi;
        bi = b0 + t * LW_N + j;
        if (bi < beats.size()) begin
          check("beat_addr", LB'(beats[bi].addr), LB'(bs + 32'(4 * j)));
          check("beat_we",   LB'(beats[bi].we),   LB'(is_w));
          if (is_w) check("beat_wdata", LB'(beats[bi].wdata), LB'(wl[32*j +: 32]));
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last_d = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            fp, bc, n, p_before;
    logic [LB-1:0] wl;
    rst = 1'b1;
    i_r_valid = 1'b0;
    d_r_valid = 1'b0;
    d_w_valid = 1'b0;
    i_addr = '0;
    d_addr = '0;
    d_wline = '0;
    @(negedge clk);
    apply_reset();
    mon_en = 1'b1;

    // Reset state
    check("rst_busy",      LB'(busy),      '0);
    check("rst_mem_valid", LB'(mem_valid), '0);
    check("rst_mem_we",    LB'(mem_we),    '0);
    check("rst_i_r_ready", LB'(i_r_ready), '0);
    check("rst_d_r_ready", LB'(d_r_ready), '0);
    check("rst_d_w_ready", LB'(d_w_ready), '0);
    check("rst_i_rline",   i_rline,        '0);
    check("rst_d_rline",   d_rline,        '0);

    // Single I read with memory always ready: latency and occupancy
    stall_mode = 0;
    do_round(1, 0, 0, 0, 32'h0000_1234, 32'h0, '0, fp, bc);
    check("i_read_latency", LB'(fp), LB'(LW_N + 1));
    check("i_read_busy",    LB'(bc), LB'(LW_N + 1));

    // D write-back with a 3-cycle stall on beat 1
    stall_mode = 2;
    wl = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    do_round(0, 1, 1, 0, 32'h0, 32'h0000_2008, wl, fp, bc);
    check("wb_stall_busy", LB'(bc), LB'(LW_N + 1 + 3));
    stall_mode = 0;

    // Tie from reset: D first, then I; repeated rounds follow the model
    apply_reset();
    do_round(1, 1, 0, 1, 32'h0000_3010, 32'h0000_5020, '0, fp, bc);
    do_round(1, 1, 0, 1, 32'h0000_3110, 32'h0000_5120, '0, fp, bc);
    do_round(0, 1, 0, 1, 32'h0, 32'h0000_5220, '0, fp, bc);
    do_round(1, 1, 0, 1, 32'h0000_3210, 32'h0000_5320, '0, fp, bc);

    // Read and write both requested on D: write-back only
    wl = {32'h1111_0004, 32'h2222_0003, 32'h3333_0002, 32'h4444_0001};
    do_round(0, 1, 1, 1, 32'h0, 32'h0000_6ABC, wl, fp, bc);

    // Reset during beat 2 aborts the transfer without a ready pulse
    p_before = pulses.size();
    i_addr = 32'h0000_4000;
    i_r_valid = 1'b1;
    n = 0;
    while (!(mem_valid && mem_addr == 32'h0000_4008) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_beat2", LB'(n < 20), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",      LB'(busy),      '0);
    check("abort_mem_valid", LB'(mem_valid), '0);
    check("abort_i_r_ready", LB'(i_r_ready), '0);
    check("abort_i_rline",   i_rline,        '0);
    rst = 1'b0;
    i_r_valid = 1'b0;
    model_last_d = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_pulse", LB'(pulses.size() - p_before), '0);
    check("abort_idle",     LB'(busy), '0);

    // Randomized rounds with random memory stalls
    stall_mode = 1;
    for (int r = 0; r < 40; r++) begin
      int  sel;
      bit  dw, dr;
      logic [LB-1:0] rwl;
      sel = $urandom_range(0, 2);
      dw  = 1'($urandom_range(0, 1));
      dr  = dw ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int j = 0; j < LW_N; j++) rwl[32*j +: 32] = $urandom;
      do_round(sel != 1, sel != 0, dw, dr, $urandom, $urandom, rwl, fp, bc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
